// File: rtl/sys_cmd_frame_gen_if.sv
// Purpose: bundles the command handshake and the UART TX byte port of sys_cmd_frame_gen.
// Latency: none. This is wiring only.
// Backpressure: CMD_READY gates command acceptance, and TX_BUSY paces the byte stream.
// Ports: slave modport  = frame generator side (takes commands, drives the TX byte port)
//        master modport = host/transmitter side (issues commands, returns TX_BUSY)
interface sys_cmd_frame_gen_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int ALU_FUNC_WIDTH = 4
);
    logic                      CMD_VLD;
    logic [1:0]                CMD_TYPE;
    logic [ADDRESS_WIDTH-1:0]  CMD_ADDR;
    logic [DATA_WIDTH-1:0]     CMD_WR_D;
    logic [DATA_WIDTH-1:0]     CMD_OP_A;
    logic [DATA_WIDTH-1:0]     CMD_OP_B;
    logic [ALU_FUNC_WIDTH-1:0] CMD_ALU_FUNC;
    logic                      CMD_READY;
    logic                      TX_BUSY;
    logic [DATA_WIDTH-1:0]     TX_P_DATA;
    logic                      TX_DATA_VLD;
    logic                      FRAME_DONE;
    logic                      FRAME_ERR;

    modport slave (
        input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WR_D, CMD_OP_A, CMD_OP_B, CMD_ALU_FUNC, TX_BUSY,
        output CMD_READY, TX_P_DATA, TX_DATA_VLD, FRAME_DONE, FRAME_ERR
    );

    modport master (
        output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_WR_D, CMD_OP_A, CMD_OP_B, CMD_ALU_FUNC, TX_BUSY,
        input  CMD_READY, TX_P_DATA, TX_DATA_VLD, FRAME_DONE, FRAME_ERR
    );
endinterface

// File: rtl/sys_cmd_frame_gen.sv
// Purpose: encodes one host command into a UART command frame and issues it one byte at a time.
// Latency: the first TX_DATA_VLD comes one cycle after ISSUE entry (two edges after acceptance), with at least 2 idle cycles between bytes.
// Backpressure: accepts only in IDLE (CMD_READY), stalls while TX_BUSY is high, and aborts with FRAME_ERR if TX_BUSY never rises.
// Ports: CLK, RST (async active-low), bus (slave modport: CMD_* in, CMD_READY out, TX_BUSY in,
//        TX_P_DATA/TX_DATA_VLD out, FRAME_DONE/FRAME_ERR one-cycle status pulses out)
module sys_cmd_frame_gen #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int ALU_FUNC_WIDTH = 4,
    parameter int ACK_TIMEOUT    = 64
) (
    input  logic              CLK,
    input  logic              RST,
    sys_cmd_frame_gen_if.slave bus
);
    localparam int TMO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [DATA_WIDTH-1:0] HDR_RF_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RF_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                typ_q, typ_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]     op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]     op_b_q, op_b_d;
    logic [ALU_FUNC_WIDTH-1:0] func_q, func_d;
    logic [1:0]                len_m1_q, len_m1_d;
    logic [1:0]                idx_q, idx_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]     tx_dat_q, tx_dat_d;
    logic                      tx_vld_q, tx_vld_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     cur_byte;

    // Index of the last byte in the frame, for each command type.
    function automatic logic [1:0] frame_last_idx(input logic [1:0] t);
        case (t)
            2'b00:   return 2'd2;
            2'b01:   return 2'd1;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    // Byte at the current index, built from the latched fields.
    always_comb begin
        cur_byte = '0;
        case (typ_q)
            2'b00: begin
                if (idx_q == 2'd0)      cur_byte = HDR_RF_WR;
                else if (idx_q == 2'd1) cur_byte = DATA_WIDTH'(addr_q);
                else                    cur_byte = wdat_q;
            end
            2'b01: begin
                if (idx_q == 2'd0) cur_byte = HDR_RF_RD;
                else               cur_byte = DATA_WIDTH'(addr_q);
            end
            2'b10: begin
                if (idx_q == 2'd0)      cur_byte = HDR_ALU_OP;
                else if (idx_q == 2'd1) cur_byte = op_a_q;
                else if (idx_q == 2'd2) cur_byte = op_b_q;
                else                    cur_byte = DATA_WIDTH'(func_q);
            end
            default: begin
                if (idx_q == 2'd0) cur_byte = HDR_ALU_NOP;
                else               cur_byte = DATA_WIDTH'(func_q);
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        typ_d    = typ_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        func_d   = func_q;
        len_m1_d = len_m1_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        tx_dat_d = tx_dat_q;
        tx_vld_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // CMD_READY is exactly "state is IDLE", so CMD_VLD alone is the handshake here.
                if (bus.CMD_VLD) begin
                    typ_d    = bus.CMD_TYPE;
                    addr_d   = bus.CMD_ADDR;
                    wdat_d   = bus.CMD_WR_D;
                    op_a_d   = bus.CMD_OP_A;
                    op_b_d   = bus.CMD_OP_B;
                    func_d   = bus.CMD_ALU_FUNC;
                    len_m1_d = frame_last_idx(bus.CMD_TYPE);
                    idx_d    = 2'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.TX_BUSY) begin
                    tx_dat_d = cur_byte;
                    tx_vld_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // The transmitter must show busy to confirm it took the byte.
                if (bus.TX_BUSY) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.TX_BUSY) begin
                    if (idx_q == len_m1_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            typ_q    <= '0;
            addr_q   <= '0;
            wdat_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            func_q   <= '0;
            len_m1_q <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            tx_dat_q <= '0;
            tx_vld_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            typ_q    <= typ_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            func_q   <= func_d;
            len_m1_q <= len_m1_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            tx_dat_q <= tx_dat_d;
            tx_vld_q <= tx_vld_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.CMD_READY   = (state_q == IDLE);
    assign bus.TX_P_DATA   = tx_dat_q;
    assign bus.TX_DATA_VLD = tx_vld_q;
    assign bus.FRAME_DONE  = done_q;
    assign bus.FRAME_ERR   = err_q;
endmodule

// File: tb/tb_sys_cmd_frame_gen.sv
// Purpose: scoreboard bench for sys_cmd_frame_gen. Directed commands push the expected byte/status events, and a monitor pops them.
// Latency: events are checked in order as the DUT pulses TX_DATA_VLD, FRAME_DONE or FRAME_ERR.
// Backpressure: a busy model raises TX_BUSY 2 cycles after each byte for 10 cycles, and a forced-busy signal holds it high.
module tb_sys_cmd_frame_gen;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int FW  = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic model_en = 1'b0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;

    always #5 clk = ~clk;

    sys_cmd_frame_gen_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALU_FUNC_WIDTH(FW)) bus ();

    assign bus.TX_BUSY = model_busy | force_busy;

    sys_cmd_frame_gen #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALU_FUNC_WIDTH(FW), .ACK_TIMEOUT(TMO)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    typedef enum logic [1:0] {EV_BYTE, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  dat;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_vld = 0;
    int   n_done = 0;
    int   n_err = 0;
    logic prev_vld = 1'b0;
    logic acc_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    task automatic push_byte(input logic [7:0] d);
        ev_t e;
        e.kind = EV_BYTE;
        e.dat  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input ev_kind_t k);
        ev_t e;
        e.kind = k;
        e.dat  = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_t k, input logic [7:0] d, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got unexpected event kind=%0d dat=%0h want none", name, k, d);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, 32'(k), 32'(e.kind));
            check(name, 32'(d), 32'(e.dat));
        end
    endtask

    // Monitor: sample outputs on the falling edge and score every pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.TX_DATA_VLD) begin
                n_vld++;
                check("vld_not_back_to_back", 32'(prev_vld), 32'd0);
                pop_check(EV_BYTE, bus.TX_P_DATA, "byte");
            end
            if (bus.FRAME_DONE || bus.FRAME_ERR)
                check("done_err_exclusive", 32'(bus.FRAME_DONE & bus.FRAME_ERR), 32'd0);
            if (bus.FRAME_DONE) begin
                n_done++;
                pop_check(EV_DONE, 8'h00, "frame_done");
            end
            if (bus.FRAME_ERR) begin
                n_err++;
                pop_check(EV_ERR, 8'h00, "frame_err");
            end
            prev_vld = bus.TX_DATA_VLD;
        end
    end

    // Busy model: TX_BUSY rises 2 cycles after a byte pulse and stays high for 10 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_en && bus.TX_DATA_VLD) begin
                repeat (2) begin @(posedge clk); #1; end
                model_busy = 1'b1;
                repeat (10) begin @(posedge clk); #1; end
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a command and hold CMD_VLD until accepted, then scramble the fields.
    task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                            input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
        int w;
        w = 0;
        bus.CMD_VLD      = 1'b1;
        bus.CMD_TYPE     = t;
        bus.CMD_ADDR     = a;
        bus.CMD_WR_D     = wd;
        bus.CMD_OP_A     = oa;
        bus.CMD_OP_B     = ob;
        bus.CMD_ALU_FUNC = f;
        while (!bus.CMD_READY && w < 500) begin
            tick();
            w++;
        end
        if (!bus.CMD_READY) fail_now("accept");
        acc_done = bus.FRAME_DONE;
        tick();
        bus.CMD_VLD      = 1'b0;
        bus.CMD_TYPE     = ~t;
        bus.CMD_ADDR     = ~a;
        bus.CMD_WR_D     = ~wd;
        bus.CMD_OP_A     = ~oa;
        bus.CMD_OP_B     = ~ob;
        bus.CMD_ALU_FUNC = ~f;
    endtask

    task automatic wait_status(input int want_done, input int want_err, input string name);
        int w;
        w = 0;
        while ((n_done < want_done || n_err < want_err) && w < 2000) begin
            tick();
            w++;
        end
        if (n_done < want_done || n_err < want_err) fail_now(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.CMD_READY), 32'd1);
        check({tag, "_tx_data"}, 32'(bus.TX_P_DATA), 32'd0);
        check({tag, "_tx_vld"}, 32'(bus.TX_DATA_VLD), 32'd0);
        check({tag, "_done"}, 32'(bus.FRAME_DONE), 32'd0);
        check({tag, "_err"}, 32'(bus.FRAME_ERR), 32'd0);
    endtask

    initial begin
        int base;
        int w;
        int k;
        bus.CMD_VLD      = 1'b0;
        bus.CMD_TYPE     = 2'b00;
        bus.CMD_ADDR     = '0;
        bus.CMD_WR_D     = '0;
        bus.CMD_OP_A     = '0;
        bus.CMD_OP_B     = '0;
        bus.CMD_ALU_FUNC = '0;

        // Reset state, then 20 idle cycles with no byte pulses.
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_no_vld", 32'(n_vld), 32'd0);

        // RF write: AA 05 3C.
        model_en = 1'b1;
        base = n_vld;
        push_byte(8'hAA); push_byte(8'h05); push_byte(8'h3C); push_ev(EV_DONE);
        send_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
        wait_status(1, 0, "rf_write_done");
        check("rf_write_vld_count", 32'(n_vld - base), 32'd3);
        check("rf_write_done_count", 32'(n_done), 32'd1);
        check("rf_write_ready_after", 32'(bus.CMD_READY), 32'd1);

        // ALU with operands, then ALU without operands accepted on the DONE cycle.
        push_byte(8'hCC); push_byte(8'h12); push_byte(8'h34); push_byte(8'h02); push_ev(EV_DONE);
        send_cmd(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
        push_byte(8'hDD); push_byte(8'h0D); push_ev(EV_DONE);
        send_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'hD);
        check("b2b_accept_on_done", 32'(acc_done), 32'd1);
        wait_status(3, 0, "alu_frames_done");

        // Busy stall: no byte while TX_BUSY is held high, first byte right after release.
        force_busy = 1'b1;
        push_byte(8'hBB); push_byte(8'h0F); push_ev(EV_DONE);
        send_cmd(2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
        base = n_vld;
        repeat (30) tick();
        check("stall_no_vld", 32'(n_vld - base), 32'd0);
        force_busy = 1'b0;
        tick();
        check("stall_release_vld", 32'(bus.TX_DATA_VLD), 32'd1);
        check("stall_release_byte", 32'(bus.TX_P_DATA), 32'hBB);
        wait_status(4, 0, "stall_frame_done");

        // Timeout: TX_BUSY never rises, FRAME_ERR 64 cycles after the byte pulse.
        model_en = 1'b0;
        repeat (3) tick();
        base = n_vld;
        push_byte(8'hAA); push_ev(EV_ERR);
        send_cmd(2'b00, 4'h7, 8'h99, 8'h00, 8'h00, 4'h0);
        w = 0;
        while (!bus.TX_DATA_VLD && w < 20) begin tick(); w++; end
        if (!bus.TX_DATA_VLD) fail_now("timeout_first_vld");
        k = 0;
        while (!bus.FRAME_ERR && k < 300) begin tick(); k++; end
        check("timeout_err_delay", 32'(k), 32'd64);
        check("timeout_ready", 32'(bus.CMD_READY), 32'd1);
        tick();
        check("timeout_vld_count", 32'(n_vld - base), 32'd1);
        check("timeout_err_count", 32'(n_err), 32'd1);

        // Reset during WAIT_LO of the second byte of an ALU frame.
        model_en = 1'b1;
        base = n_vld;
        push_byte(8'hCC); push_byte(8'h12);
        send_cmd(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
        w = 0;
        while (n_vld < base + 2 && w < 200) begin tick(); w++; end
        if (n_vld < base + 2) fail_now("midreset_second_byte");
        w = 0;
        while (!bus.TX_BUSY && w < 20) begin tick(); w++; end
        if (!bus.TX_BUSY) fail_now("midreset_busy");
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (15) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("midreset_no_done", 32'(n_done), 32'd4);
        check("midreset_no_err", 32'(n_err), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
